// File: rtl/comb_logic_gates.sv
// Registered bitwise AND/OR/XOR/NOT plus reductions of a; 1-cycle latency.
// No backpressure: en=0 holds every result, valid stays set until reset.
module comb_logic_gates #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] out_and,
   output logic [WIDTH-1:0] out_or,
   output logic [WIDTH-1:0] out_xor,
   output logic [WIDTH-1:0] out_not,
   output logic             red_and,
   output logic             red_or,
   output logic             red_xor,
   output logic             valid
);

   logic [WIDTH-1:0] and_d, and_q;
   logic [WIDTH-1:0] or_d,  or_q;
   logic [WIDTH-1:0] xor_d, xor_q;
   logic [WIDTH-1:0] not_d, not_q;
   logic             red_and_d, red_and_q;
   logic             red_or_d,  red_or_q;
   logic             red_xor_d, red_xor_q;
   logic             valid_d,   valid_q;

   always_comb begin
      and_d     = and_q;
      or_d      = or_q;
      xor_d     = xor_q;
      not_d     = not_q;
      red_and_d = red_and_q;
      red_or_d  = red_or_q;
      red_xor_d = red_xor_q;
      valid_d   = valid_q;
      if (en) begin
         and_d     = a & b;
         or_d      = a | b;
         xor_d     = a ^ b;
         not_d     = ~a;
         red_and_d = &a;
         red_or_d  = |a;
         red_xor_d = ^a;
         valid_d   = 1'b1;
      end
   end

   // Reset wins over en, so it lives in the register stage rather than in the next-state logic.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         and_q     <= '0;
         or_q      <= '0;
         xor_q     <= '0;
         not_q     <= '0;
         red_and_q <= 1'b0;
         red_or_q  <= 1'b0;
         red_xor_q <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         and_q     <= and_d;
         or_q      <= or_d;
         xor_q     <= xor_d;
         not_q     <= not_d;
         red_and_q <= red_and_d;
         red_or_q  <= red_or_d;
         red_xor_q <= red_xor_d;
         valid_q   <= valid_d;
      end
   end

   assign out_and = and_q;
   assign out_or  = or_q;
   assign out_xor = xor_q;
   assign out_not = not_q;
   assign red_and = red_and_q;
   assign red_or  = red_or_q;
   assign red_xor = red_xor_q;
   assign valid   = valid_q;

endmodule

// File: tb/tb_comb_logic_gates.sv
// Scoreboard bench for comb_logic_gates at WIDTH 8 (directed + random), 1 and 16 (random).
module tb_comb_logic_gates;

   typedef struct {
      logic [15:0] and_v;
      logic [15:0] or_v;
      logic [15:0] xor_v;
      logic [15:0] not_v;
      logic        ra;
      logic        ro;
      logic        rx;
      logic        v;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        en8, en1, en16;
   logic [7:0]  a8, b8;
   logic [0:0]  a1, b1;
   logic [15:0] a16, b16;

   logic [7:0]  and8, or8, xor8, not8;
   logic [0:0]  and1, or1, xor1, not1;
   logic [15:0] and16, or16, xor16, not16;
   logic        ra8, ro8, rx8, v8;
   logic        ra1, ro1, rx1, v1;
   logic        ra16, ro16, rx16, v16;

   comb_logic_gates #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .en(en8), .a(a8), .b(b8),
      .out_and(and8), .out_or(or8), .out_xor(xor8), .out_not(not8),
      .red_and(ra8), .red_or(ro8), .red_xor(rx8), .valid(v8));

   comb_logic_gates #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .en(en1), .a(a1), .b(b1),
      .out_and(and1), .out_or(or1), .out_xor(xor1), .out_not(not1),
      .red_and(ra1), .red_or(ro1), .red_xor(rx1), .valid(v1));

   comb_logic_gates #(.WIDTH(16)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .en(en16), .a(a16), .b(b16),
      .out_and(and16), .out_or(or16), .out_xor(xor16), .out_not(not16),
      .red_and(ra16), .red_or(ro16), .red_xor(rx16), .valid(v16));

   int   tests_run = 0;
   int   tests_failed = 0;
   exp_t m8, m1, m16;
   exp_t q8[$], q1[$], q16[$];

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference behaviour of one register edge, operands zero-extended into 16 bits.
   function automatic exp_t model(input exp_t cur, input logic r, input logic e,
                                  input logic [15:0] a, input logic [15:0] b, input int w);
      exp_t        n;
      logic [15:0] mask;
      mask = (w >= 16) ? 16'hFFFF : ((16'h1 << w) - 16'h1);
      n = cur;
      if (!r) begin
         n.and_v = '0; n.or_v = '0; n.xor_v = '0; n.not_v = '0;
         n.ra = 1'b0; n.ro = 1'b0; n.rx = 1'b0; n.v = 1'b0;
      end else if (e) begin
         n.and_v = a & b & mask;
         n.or_v  = (a | b) & mask;
         n.xor_v = (a ^ b) & mask;
         n.not_v = ~a & mask;
         n.ra    = &(a | ~mask);
         n.ro    = |(a & mask);
         n.rx    = ^(a & mask);
         n.v     = 1'b1;
      end
      return n;
   endfunction

   task automatic cmp(input string tag, input exp_t o, input exp_t e);
      chk({tag, "_and"}, o.and_v, e.and_v);
      chk({tag, "_or"},  o.or_v,  e.or_v);
      chk({tag, "_xor"}, o.xor_v, e.xor_v);
      chk({tag, "_not"}, o.not_v, e.not_v);
      chk({tag, "_rand"}, {15'd0, o.ra}, {15'd0, e.ra});
      chk({tag, "_ror"},  {15'd0, o.ro}, {15'd0, e.ro});
      chk({tag, "_rxor"}, {15'd0, o.rx}, {15'd0, e.rx});
      chk({tag, "_valid"}, {15'd0, o.v}, {15'd0, e.v});
   endtask

   // One cycle: drive at negedge, push expectations, sample #1 after the edge and pop.
   task automatic cyc(input string name, input logic r, input logic e,
                      input logic [7:0] aa, input logic [7:0] bb);
      exp_t o;
      @(negedge clk);
      rst_n = r;
      en8 = e; a8 = aa; b8 = bb;
      en1 = 1'($urandom); a1 = 1'($urandom); b1 = 1'($urandom);
      en16 = 1'($urandom); a16 = 16'($urandom); b16 = 16'($urandom);
      m8  = model(m8,  r, e,    {8'd0, aa},  {8'd0, bb},  8);
      m1  = model(m1,  r, en1,  {15'd0, a1}, {15'd0, b1}, 1);
      m16 = model(m16, r, en16, a16,         b16,         16);
      q8.push_back(m8);
      q1.push_back(m1);
      q16.push_back(m16);
      @(posedge clk);
      #1;
      o.and_v = {8'd0, and8}; o.or_v = {8'd0, or8}; o.xor_v = {8'd0, xor8}; o.not_v = {8'd0, not8};
      o.ra = ra8; o.ro = ro8; o.rx = rx8; o.v = v8;
      cmp({name, "_w8"}, o, q8.pop_front());
      o.and_v = {15'd0, and1}; o.or_v = {15'd0, or1}; o.xor_v = {15'd0, xor1}; o.not_v = {15'd0, not1};
      o.ra = ra1; o.ro = ro1; o.rx = rx1; o.v = v1;
      cmp({name, "_w1"}, o, q1.pop_front());
      o.and_v = and16; o.or_v = or16; o.xor_v = xor16; o.not_v = not16;
      o.ra = ra16; o.ro = ro16; o.rx = rx16; o.v = v16;
      cmp({name, "_w16"}, o, q16.pop_front());
   endtask

   initial begin
      rst_n = 1'b0;
      en8 = 1'b0; a8 = '0; b8 = '0;
      en1 = 1'b0; a1 = '0; b1 = '0;
      en16 = 1'b0; a16 = '0; b16 = '0;
      m8 = model(m8, 1'b0, 1'b0, 16'd0, 16'd0, 8);
      m1 = m8;
      m16 = m8;

      cyc("rst", 1'b0, 1'b1, 8'h00, 8'h00);
      cyc("rst", 1'b0, 1'b1, 8'h00, 8'h00);
      cyc("c1", 1'b1, 1'b1, 8'h00, 8'h00);
      chk("c1_lit_not", {8'd0, not8}, 16'h00FF);
      cyc("c2a", 1'b1, 1'b1, 8'h01, 8'h00);
      cyc("c2b", 1'b1, 1'b1, 8'h01, 8'h01);
      chk("c2_lit_and", {8'd0, and8}, 16'h0001);
      cyc("c3a", 1'b1, 1'b1, 8'h00, 8'h01);
      cyc("c3b", 1'b1, 1'b1, 8'hFF, 8'h0F);
      chk("c3_lit_and", {8'd0, and8}, 16'h000F);
      chk("c3_lit_rand", {15'd0, ra8}, 16'h0001);

      cyc("c4cap", 1'b1, 1'b1, 8'hAA, 8'h55);
      for (int i = 0; i < 4; i++) begin
         cyc("c4hold", 1'b1, 1'b0, 8'($urandom), 8'($urandom));
         chk("c4_lit_not", {8'd0, not8}, 16'h0055);
      end

      cyc("c5rst", 1'b0, 1'b1, 8'hFF, 8'h00);
      chk("c5_lit_valid", {15'd0, v8}, 16'h0000);
      cyc("c5rel", 1'b1, 1'b1, 8'h3C, 8'hA5);
      chk("c5_lit_xor", {8'd0, xor8}, 16'h0099);

      for (int i = 0; i < 200; i++)
         cyc("sweep", 1'b1, 1'($urandom), 8'($urandom), 8'($urandom));

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
